mac_dot_sequencer: RTL

- Upstream feeder for the floating-point multiply-accumulate stage (`mac_syv`-class, 9-cycle latency). That stage's accumulate input is its own output fed back, selected by `control`.
- Accepts a stream of (a, b, last) element pairs and issues them to the MAC.
- The MAC pipeline has one accumulation chain per pipeline slot, so elements of one dot product are issued only in slot 0, once every MAC_LAT cycles. All other slots carry clearing bubbles.
- Captures the finished dot product from the MAC output and presents it on a valid/ready result port, together with the element count.

---
 rtl/mac_seq_pkg.sv | 13 +
 rtl/mac_slot_timer.sv | 31 +++
 rtl/mac_dot_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared constants and issue-op encoding for the MAC dot-product sequencer.
package mac_seq_pkg;

  localparam int          MAC_LAT_DEFAULT = 9;
  localparam logic [31:0] FP_ZERO         = 32'h0000_0000;

  typedef enum logic [1:0] {
    OP_BUBBLE,
    OP_ELEM,
    OP_HOLD
  } issue_op_e;

endpackage

// File: rtl/mac_slot_timer.sv
// Free-running issue-phase counter; slot0 marks the one slot that carries
// the active dot-product accumulation chain.
module mac_slot_timer
  import mac_seq_pkg::*;
#(
  parameter int LAT = MAC_LAT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  output logic slot0
);

  localparam int PW = (LAT > 1) ? $clog2(LAT) : 1;

  logic [PW-1:0] phase;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= '0;
    end else if (phase == PW'(LAT - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

  assign slot0 = (phase == '0);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Feeds (a, b, last) beats into a MAC_LAT-deep FP multiply-accumulate and
// returns each finished dot product on a valid/ready port.
// Optional: define MAC_DOT_SEQ_ABORT_EN to add the `abort` input.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int MAC_LAT = MAC_LAT_DEFAULT,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
`ifdef MAC_DOT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic             in_last,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic             mac_clear,
  output logic             mac_valid,
  input  logic [31:0]      mac_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [CNT_W-1:0] res_count
);

  logic             slot0;
  logic             slot_free;
  logic             open;
  logic             pending;
  logic             capture;
  logic             accept;
  logic             abort_now;
  logic [CNT_W-1:0] elem_cnt;
  issue_op_e        op;

  mac_slot_timer #(.LAT(MAC_LAT)) u_timer (
    .clock (clock),
    .reset (reset),
    .slot0 (slot0)
  );

`ifdef MAC_DOT_SEQ_ABORT_EN
  // A request raised off-slot is remembered until the next slot 0 applies it.
  logic abort_req;

  always_ff @(posedge clock) begin
    if (reset) begin
      abort_req <= 1'b0;
    end else if (abort_now) begin
      abort_req <= 1'b0;
    end else if (abort) begin
      abort_req <= 1'b1;
    end
  end

  assign abort_now = slot0 && (abort || abort_req);
`else
  assign abort_now = 1'b0;
`endif

  assign mac_valid = !reset;
  assign slot_free = !res_valid || res_ready;
  assign capture   = slot0 && pending && slot_free && !abort_now;
  assign in_ready  = slot0 && !abort_now && !(pending && !slot_free);
  assign accept    = in_valid && in_ready;

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    op = OP_BUBBLE;
    if (slot0 && !abort_now) begin
      if (accept) begin
        op = OP_ELEM;
      end else if (open || (pending && !slot_free)) begin
        // A blocked result keeps circulating and is offered again next lap.
        op = OP_HOLD;
      end
    end
  end

  always_comb begin
    mac_a     = FP_ZERO;
    mac_b     = FP_ZERO;
    mac_clear = 1'b1;
    case (op)
      OP_ELEM: begin
        mac_a     = in_a;
        mac_b     = in_b;
        mac_clear = !open;
      end
      OP_HOLD: mac_clear = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      open      <= 1'b0;
      pending   <= 1'b0;
      elem_cnt  <= '0;
      res_valid <= 1'b0;
      res_data  <= FP_ZERO;
      res_count <= '0;
    end else begin
      if (capture) begin
        res_data  <= mac_q;
        res_count <= elem_cnt;
        res_valid <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      if (abort_now) begin
        open     <= 1'b0;
        pending  <= 1'b0;
        elem_cnt <= '0;
      end else if (accept) begin
        elem_cnt <= open ? elem_cnt + 1'b1 : CNT_W'(1);
        open     <= !in_last;
        // Capture of the previous result and a new last beat may coincide.
        pending  <= in_last ? 1'b1 : (capture ? 1'b0 : pending);
      end else if (capture) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
